// File: rtl/ssio_sdr_in_diff_mon.sv
// Differential SDR input capture with a training-pattern lock monitor.
// Define SSIO_SDR_IN_ERR_CNT_EN to build the saturating locked-error counter on err_count.
module ssio_sdr_in_diff_mon #(
  parameter string             TARGET        = "GENERIC",
  parameter int                WIDTH         = 1,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = WIDTH'(32'hA),
  parameter int                LOCK_COUNT    = 8,
  parameter int                UNLOCK_ERRORS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_d_p,
  input  logic [WIDTH-1:0] input_d_n,
  input  logic             relock,
  output logic [WIDTH-1:0] output_q,
  output logic             output_valid,
  output logic             locked,
  output logic             diff_err,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_CNT = 8'(UNLOCK_ERRORS);

  logic [WIDTH-1:0] w_s1_p;
  logic [WIDTH-1:0] w_s1_n;
  logic             w_s1_err;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_match_cnt;
  logic [7:0]       w_match_cnt_nxt;
  logic [7:0]       w_match_inc;
  logic [7:0]       r_bad_cnt;
  logic [7:0]       w_bad_cnt_nxt;
  logic [7:0]       w_bad_inc;
  logic [WIDTH-1:0] r_expect;
  logic [WIDTH-1:0] w_expect_nxt;

  // Stage 1 sits in the I/O cell on vendor targets; behaviour is identical everywhere.
  generate
    if (TARGET == "XILINX") begin : g_cap
      (* IOB = "TRUE" *) logic [WIDTH-1:0] r_p;
      (* IOB = "TRUE" *) logic [WIDTH-1:0] r_n;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p <= {WIDTH{1'b0}};
          r_n <= {WIDTH{1'b0}};
        end else begin
          r_p <= input_d_p;
          r_n <= input_d_n;
        end
      end
      assign w_s1_p = r_p;
      assign w_s1_n = r_n;
    end else if (TARGET == "ALTERA") begin : g_cap
      (* useioff = 1 *) logic [WIDTH-1:0] r_p;
      (* useioff = 1 *) logic [WIDTH-1:0] r_n;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p <= {WIDTH{1'b0}};
          r_n <= {WIDTH{1'b0}};
        end else begin
          r_p <= input_d_p;
          r_n <= input_d_n;
        end
      end
      assign w_s1_p = r_p;
      assign w_s1_n = r_n;
    end else begin : g_cap
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_n;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p <= {WIDTH{1'b0}};
          r_n <= {WIDTH{1'b0}};
        end else begin
          r_p <= input_d_p;
          r_n <= input_d_n;
        end
      end
      assign w_s1_p = r_p;
      assign w_s1_n = r_n;
    end
  endgenerate

  // A lane whose two legs agree cannot carry a valid differential bit.
  assign w_s1_err    = |(w_s1_p ~^ w_s1_n);
  assign w_match_inc = (r_match_cnt == 8'hFF) ? 8'hFF : (r_match_cnt + 8'd1);
  assign w_bad_inc   = (r_bad_cnt == 8'hFF) ? 8'hFF : (r_bad_cnt + 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_match_cnt <= 8'd0;
      r_bad_cnt   <= 8'd0;
      r_expect    <= {WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_bad_cnt   <= w_bad_cnt_nxt;
      r_expect    <= w_expect_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_bad_cnt_nxt   = r_bad_cnt;
    w_expect_nxt    = r_expect;
    if (relock) begin
      w_state_nxt     = ST_HUNT;
      w_match_cnt_nxt = 8'd0;
      w_bad_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (!w_s1_err && (w_s1_p == TRAIN_PATTERN)) begin
            w_match_cnt_nxt = 8'd1;
            w_expect_nxt    = ~TRAIN_PATTERN;
            w_state_nxt     = (LOCK_CNT <= 8'd1) ? ST_LOCKED : ST_TRAIN;
          end else begin
            w_match_cnt_nxt = 8'd0;
          end
        end
        ST_TRAIN: begin
          // A bad word drops to HUNT without being re-checked as a new first match.
          if (!w_s1_err && (w_s1_p == r_expect)) begin
            w_match_cnt_nxt = w_match_inc;
            w_expect_nxt    = ~r_expect;
            w_state_nxt     = (w_match_inc >= LOCK_CNT) ? ST_LOCKED : ST_TRAIN;
          end else begin
            w_match_cnt_nxt = 8'd0;
            w_state_nxt     = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (w_s1_err) begin
            if (w_bad_inc >= UNLOCK_CNT) begin
              w_state_nxt     = ST_HUNT;
              w_bad_cnt_nxt   = 8'd0;
              w_match_cnt_nxt = 8'd0;
            end else begin
              w_bad_cnt_nxt = w_bad_inc;
            end
          end else begin
            w_bad_cnt_nxt = 8'd0;
          end
        end
        default: begin
          w_state_nxt     = ST_HUNT;
          w_match_cnt_nxt = 8'd0;
          w_bad_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_q     <= {WIDTH{1'b0}};
      output_valid <= 1'b0;
      locked       <= 1'b0;
      diff_err     <= 1'b0;
    end else begin
      output_q     <= w_s1_p;
      output_valid <= (r_state == ST_LOCKED) && !w_s1_err;
      locked       <= (w_state_nxt == ST_LOCKED);
      diff_err     <= w_s1_err;
    end
  end

`ifdef SSIO_SDR_IN_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Survives loss of lock; only reset and relock clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 16'd0;
    end else if (relock) begin
      r_err_count <= 16'd0;
    end else if ((r_state == ST_LOCKED) && w_s1_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'd0;
`endif

endmodule
